// File: rtl/rotator_seq_pkg.sv
// Shared definitions for the sequential rotator: FSM state encoding and
// rotate-direction constants.
package rotator_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam logic ROL = 1'b0;
  localparam logic ROR = 1'b1;

endpackage

// File: rtl/rotator_seq_if.sv
// Request/result bundle between a requester (master) and the rotator (slave).
interface rotator_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             Start;
  logic             Dir;
  logic [WIDTH-1:0] A;
  logic [AMT_W-1:0] Imm;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;

  modport master (output Start, Dir, A, Imm, input Result, Busy, Done);
  modport slave  (input Start, Dir, A, Imm, output Result, Busy, Done);
endinterface

// File: rtl/rotator_seq_rot1.sv
// Combinational single-position rotator: ROL wraps the MSB into bit 0,
// ROR wraps bit 0 into the MSB.
module rot1
  import rotator_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  output logic [WIDTH-1:0] rotated
);

  assign rotated = (dir == ROR) ? {value[0], value[WIDTH-1:1]}
                                : {value[WIDTH-2:0], value[WIDTH-1]};

endmodule

// File: rtl/rotator_seq.sv
// Sequential rotator: rotates A by Imm positions, one bit per cycle, using a
// single-step rotator and a down-counter. Done pulses in the FIN state.
module rotator_seq
  import rotator_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rotator_seq_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   rot_value;

  rot1 #(.WIDTH(WIDTH)) u_rot1 (
    .value   (result_q),
    .dir     (dir_q),
    .rotated (rot_value)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE, FIN: begin
        // FIN accepts a new request so back-to-back operations lose no cycle
        if (bus.Start) begin
          result_d = bus.A;
          cnt_d    = bus.Imm;
          dir_d    = bus.Dir;
          state_d  = (bus.Imm != '0) ? RUN : FIN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d = rot_value;
        cnt_d    = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      dir_q    <= ROL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Busy   = (state_q == RUN);
  assign bus.Done   = (state_q == FIN);

endmodule

// File: tb/tb_rotator_seq.sv
// Self-checking bench for rotator_seq: table of vectors plus hand-written
// multi-cycle sequences, with a scoreboard checked on every Done pulse.
module tb_rotator_seq;
  import rotator_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rotator_seq_if #(.WIDTH(16), .AMT_W(4)) bus ();

  rotator_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [3:0]  imm;
    logic        dir;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    logic [31:0] t;
    t = {x, x} << n;
    return t[31:16];
  endfunction

  // Scoreboard: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.Busy && bus.Done) chk("busy_and_done", 1, 0);
      if (bus.Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("result", bus.Result, e.res);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called in the cycle after a posedge; returns in cycle 1 of the request.
  task automatic start_op(input logic [15:0] a, input logic [3:0] imm, input logic dir,
                          input logic [15:0] exp, input bit push);
    sb_t e;
    bus.Start = 1'b1;
    bus.A     = a;
    bus.Imm   = imm;
    bus.Dir   = dir;
    if (push) begin
      e.res = exp;
      e.cyc = cyc + int'(imm) + 1;
      sb.push_back(e);
    end
    $display("op A=0x%04h Imm=%0d Dir=%0d expect 0x%04h", a, imm, dir, exp);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.A     = 16'($urandom);
    bus.Imm   = 4'($urandom);
    bus.Dir   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    vecs[0] = '{16'h8001, 4'd1,  ROL, 16'h0003};
    vecs[1] = '{16'h0001, 4'd4,  ROR, 16'h1000};
    vecs[2] = '{16'h1000, 4'd4,  ROL, 16'h0001};
    vecs[3] = '{16'hBEEF, 4'd0,  ROL, 16'hBEEF};
    vecs[4] = '{16'h00F0, 4'd15, ROL, 16'h0078};
    vecs[5] = '{16'h8000, 4'd15, ROR, 16'h0001};
    vecs[6] = '{16'h1234, 4'd8,  ROL, 16'h3412};
    vecs[7] = '{16'hA5C3, 4'd3,  ROR, 16'h74B8};

    // Reset must dominate a pending Start
    rst_n = 1'b0;
    bus.Start = 1'b1; bus.A = 16'hFFFF; bus.Imm = 4'd3; bus.Dir = ROL;
    step(3);
    chk("reset_result", bus.Result, 0);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_done", bus.Done, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].imm, vecs[i].dir, vecs[i].exp, 1'b1);
      chk($sformatf("v%0d_busy_c1", i), bus.Busy, (vecs[i].imm != 0));
      chk($sformatf("v%0d_done_c1", i), bus.Done, (vecs[i].imm == 0));
      wait_idle();
    end

    // Start during RUN is ignored
    start_op(16'h00F0, 4'd15, ROL, 16'h0078, 1'b1);
    step(2);
    bus.Start = 1'b1; bus.A = 16'h1234; bus.Imm = 4'd1; bus.Dir = ROR;
    $display("op ignored A=0x1234 during RUN");
    step(1);
    bus.Start = 1'b0;
    chk("ignored_busy", bus.Busy, 1);
    wait_idle();

    // Reset aborts a rotation: no Done pulse afterwards
    start_op(16'h00F0, 4'd15, ROL, 16'h0000, 1'b0);
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("abort_result", bus.Result, 0);
    chk("abort_busy", bus.Busy, 0);
    chk("abort_done", bus.Done, 0);
    rst_n = 1'b1;
    step(20);

    // Back-to-back: new Start accepted in the FIN cycle
    start_op(16'h0001, 4'd2, ROL, 16'h0004, 1'b1);
    step(2);
    chk("b2b_fin", bus.Done, 1);
    start_op(16'h0002, 4'd1, ROR, 16'h0001, 1'b1);
    chk("b2b_busy", bus.Busy, 1);
    wait_idle();

    // Lossless: ROR n of (ROL n of X) returns X
    for (int i = 0; i < 6; i++) begin
      logic [15:0] x, y;
      logic [3:0]  n;
      x = 16'($urandom);
      n = 4'($urandom_range(0, 15));
      y = rotl(x, int'(n));
      start_op(x, n, ROL, y, 1'b1);
      wait_idle();
      start_op(y, n, ROR, x, 1'b1);
      wait_idle();
    end

    step(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rotator_seq.md
ROTATOR_SEQ -- requirements
Module: rotator_seq

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter AMT_W, default 4, rotate-amount width (log2 WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 Start  input  1  request strobe; sampled every cycle.
REQ-006 Dir  input  1  direction; 0 = rotate left (ROL), 1 = rotate right (ROR).
REQ-007 A  input  WIDTH  operand; sampled only on an accepted Start.
REQ-008 Imm  input  AMT_W  rotate amount 0..WIDTH-1; sampled only on an accepted Start.
REQ-009 Result  output  WIDTH  rotated value; registered output.
REQ-010 Busy  output  1  high while a rotation is in progress.
REQ-011 Done  output  1  one-cycle pulse; Result is final in that cycle.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-013 Start SHALL be accepted only in IDLE or FIN; Start in RUN SHALL be ignored with no state, counter or Result change.
REQ-014 On an accepted Start, the block SHALL load A into Result, Imm into the remaining-count register, latch Dir, and enter RUN if Imm != 0, else FIN.
REQ-015 In RUN, each cycle SHALL rotate Result by exactly one bit in the latched direction and decrement the count; ROL moves bit WIDTH-1 into bit 0, ROR moves bit 0 into bit WIDTH-1.
REQ-016 When the count decrements to 0, the next state SHALL be FIN.
REQ-017 FIN SHALL last one cycle, drive Done=1, then go to IDLE unless a new Start is accepted in that cycle, in which case REQ-014 applies (back-to-back).
REQ-018 Latency: Start accepted at cycle 0 SHALL give Done at cycle Imm+1; Imm=0 gives Done at cycle 1 with Result = A.
REQ-019 Busy SHALL be 1 exactly in RUN; Done SHALL be 1 exactly in FIN.
REQ-020 Result SHALL hold its value in IDLE and FIN until the next accepted Start.
REQ-021 Rotation SHALL be lossless: ROR by n of (ROL by n of X) equals X for all X, n.
REQ-022 Changes on A, Imm, Dir outside an accepted Start SHALL have no effect.

Reset
REQ-023 When rst_n=0 at a rising edge: state = IDLE, Result = 0, count = 0, latched Dir = 0, Busy = 0, Done = 0.
REQ-024 Reset SHALL override Start in the same cycle and SHALL abort a rotation in progress with no Done pulse.
REQ-025 First Start SHALL be accepted in the first cycle with rst_n=1.

Structure
REQ-026 Shared ALU package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, FIN=2'b10) and the Dir constants ROL=1'b0, ROR=1'b1.
REQ-027 One sub-module SHALL be used: rot1, a combinational WIDTH-bit single-position rotator (inputs value, dir; output rotated value); the FSM and counter live in rotator_seq.
REQ-028 No multi-bit barrel logic; cost SHALL be one WIDTH-bit register, one AMT_W counter, 2-bit state.

Verification
REQ-029 A=0x8001, Imm=1, Dir=ROL, Start at cycle 0 -> Busy=1 at cycle 1, Done=1 at cycle 2, Result=0x0003.
REQ-030 A=0x0001, Imm=4, Dir=ROR -> Done at cycle 5, Result=0x1000; then ROL by 4 of 0x1000 -> 0x0001.
REQ-031 A=0xBEEF, Imm=0 -> Done at cycle 1, Busy never asserted, Result=0xBEEF.
REQ-032 A=0x00F0, Imm=15, ROL; second Start (A=0x1234) at cycle 3 -> ignored; Done at cycle 16, Result=0x0078.
REQ-033 Rotation in progress, rst_n=0 at cycle 3 -> at cycle 4 Result=0, Busy=0, no Done pulse then or later.
REQ-034 Start in FIN cycle with A=0x0002, Imm=1, ROR -> next cycle Busy=1, Done one cycle later, Result=0x0001.
